// File: rtl/div_unit.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring core on magnitudes plus a sign-fix cycle.
// Optional build macro DIV_EARLY_OUT_EN adds a one-cycle path for |A| < |B|.
module div_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST_ITER = CW'(n - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [n:0]    rem_reg;
    logic [n-1:0]  quo_reg;
    logic [n-1:0]  dvs_reg;
    logic          sign_q_reg;
    logic          sign_r_reg;
    logic          rem_sel_reg;

    logic          is_signed;
    logic          a_neg;
    logic          b_neg;
    logic [n-1:0]  a_mag;
    logic [n-1:0]  b_mag;
    logic          div_zero;
    logic          overflow;
    logic          early;
    logic          fast;
    logic [n-1:0]  fast_res;
    logic [n:0]    rem_sh;
    logic [n:0]    trial;
    logic [n-1:0]  q_fix;
    logic [n-1:0]  r_fix;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & A[n-1];
    assign b_neg     = is_signed & B[n-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;
    assign div_zero  = (B == '0);
    assign overflow  = is_signed & (A == {1'b1, {(n-1){1'b0}}}) & (B == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = ~div_zero & (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign fast = div_zero | overflow | early;

    // Remainder results on every fast path equal the raw dividend except overflow REM (0).
    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = op[1] ? A : '1;
        else if (overflow)
            fast_res = op[1] ? '0 : A;
        else if (early)
            fast_res = op[1] ? A : '0;
    end

    // R stays below the divisor, so the shifted value fits n+1 bits and trial[n] is the borrow.
    assign rem_sh = {rem_reg[n-1:0], quo_reg[n-1]};
    assign trial  = rem_sh - {1'b0, dvs_reg};
    assign q_fix  = sign_q_reg ? -quo_reg : quo_reg;
    assign r_fix  = sign_r_reg ? -rem_reg[n-1:0] : rem_reg[n-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            rem_sel_reg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (fast) begin
                            result <= fast_res;
                            done   <= 1'b1;
                        end else begin
                            rem_sel_reg <= op[1];
                            sign_q_reg  <= a_neg ^ b_neg;
                            sign_r_reg  <= a_neg;
                            rem_reg     <= '0;
                            quo_reg     <= a_mag;
                            dvs_reg     <= b_mag;
                            cnt_reg     <= '0;
                            busy        <= 1'b1;
                            state_reg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[n]) begin
                        rem_reg <= trial;
                        quo_reg <= {quo_reg[n-2:0], 1'b1};
                    end else begin
                        rem_reg <= rem_sh;
                        quo_reg <= {quo_reg[n-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER)
                        state_reg <= FIX;
                end
                FIX: begin
                    result    <= rem_sel_reg ? r_fix : q_fix;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit: results, latency, busy length, done width, reset abort, ignored restart.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
    localparam int EL = 0;
`else
    localparam int EL = 33;
`endif

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    div_unit #(.n(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept edge is the posedge after start is driven; latency counts edges after it.
    task automatic run_vec(input vec_t v);
        int lat_cnt;
        int busy_cnt;
        logic got;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0; lat_cnt = -1; busy_cnt = 0; res = '0;
        for (int k = 0; k <= 60; k++) begin
            if (done) begin
                got = 1'b1; lat_cnt = k; res = result;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check({v.name, " done_seen"}, 32'(got), 32'd1);
        check({v.name, " result"}, res, v.exp);
        check({v.name, " latency"}, 32'(lat_cnt), 32'(v.lat));
        check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(v.lat));
        check({v.name, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({v.name, " done_pulse"}, 32'(done), 32'd0);
        $display("txn %-14s op=%0d A=%h B=%h result=%h latency=%0d", v.name, v.op, v.a, v.b, res, lat_cnt);
    endtask

    initial begin
        vec_t vecs[$];
        int dones;
        logic [31:0] last_res;

        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

        vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"div_m100_7",   OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   33});
        vecs.push_back('{"rem_m100_7",   OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33});
        vecs.push_back('{"div_100_m7",   OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33});
        vecs.push_back('{"rem_100_m7",   OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          33});
        vecs.push_back('{"div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{"rem_5_0",      OP_REM,  32'd5,          32'd0,          32'd5,          0});
        vecs.push_back('{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   0});
        vecs.push_back('{"div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   0});
        vecs.push_back('{"rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          0});
        vecs.push_back('{"divu_3_10",    OP_DIVU, 32'd3,          32'd10,         32'd0,          EL});
        vecs.push_back('{"remu_3_10",    OP_REMU, 32'd3,          32'd10,         32'd3,          EL});
        vecs.push_back('{"rem_m3_10",    OP_REM,  32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   EL});
        vecs.push_back('{"divu_big",     OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          EL});
        vecs.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33});
        vecs.push_back('{"div_min_2",    OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33});
        vecs.push_back('{"remu_max_10",  OP_REMU, 32'hFFFFFFFF,   32'd10,         32'd5,          33});

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset ten edges into a DIVU 1000/3 must abort with no done.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        rst = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midreset no_done", 32'(dones), 32'd0);
        $display("txn midreset       dones_after=%0d", dones);

        // A second start during CALC is dropped; only the first division completes.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = OP_REMU; a = 32'd50; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; last_res = '0;
        repeat (70) begin
            if (done) begin
                dones++;
                last_res = result;
            end
            @(posedge clk); #1;
        end
        check("restart done_count", 32'(dones), 32'd1);
        check("restart result", last_res, 32'd14);
        $display("txn restart        dones=%0d result=%h", dones, last_res);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
